// File: rtl/chunked_sequential_adder.sv
// Multi-cycle N-bit adder/subtractor that processes W bits per clock,
// carrying between chunks through a register; operands and results use valid/ready.
module chunked_sequential_adder #(
   parameter int N = 32,
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         carry_in,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] c,
   output logic         carry_out,
   output logic         overflow
);

   localparam int K  = N / W;
   localparam int IW = (K > 1) ? $clog2(K) : 1;

   if ((W <= 0) || (N % W != 0)) begin : gen_bad_chunk_width
      $error("chunked_sequential_adder: N must be a positive multiple of W");
   end

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t          state_q, state_d;
   logic [N-1:0]    aOp_q, aOp_d;
   logic [N-1:0]    bOp_q, bOp_d;
   logic [N-1:0]    sum_q, sum_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            carry_q, carry_d;
   logic            carryOut_q, carryOut_d;
   logic            overflow_q, overflow_d;

   logic [W-1:0]    aChunk, bChunk;
   logic [W:0]      chunkSum;
   logic            lastChunk;

   // Subtraction is folded into the captured operands (b inverted, carry forced to 1),
   // so the BUSY datapath is a plain W-bit adder.
   always_comb begin
      aChunk    = aOp_q[idx_q*W +: W];
      bChunk    = bOp_q[idx_q*W +: W];
      chunkSum  = {1'b0, aChunk} + {1'b0, bChunk} + {{W{1'b0}}, carry_q};
      lastChunk = (idx_q == IW'(K - 1));
   end

   always_comb begin
      state_d    = state_q;
      aOp_d      = aOp_q;
      bOp_d      = bOp_q;
      sum_d      = sum_q;
      idx_d      = idx_q;
      carry_d    = carry_q;
      carryOut_d = carryOut_q;
      overflow_d = overflow_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = BUSY;
               aOp_d   = a;
               bOp_d   = sub ? ~b : b;
               carry_d = sub | carry_in;
               idx_d   = '0;
            end
         end
         BUSY: begin
            sum_d[idx_q*W +: W] = chunkSum[W-1:0];
            carry_d             = chunkSum[W];
            if (lastChunk) begin
               state_d    = DONE;
               carryOut_d = chunkSum[W];
               // The top bit of the last chunk is the result sign bit.
               overflow_d = (aOp_q[N-1] == bOp_q[N-1]) && (chunkSum[W-1] != aOp_q[N-1]);
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         aOp_q      <= '0;
         bOp_q      <= '0;
         sum_q      <= '0;
         idx_q      <= '0;
         carry_q    <= 1'b0;
         carryOut_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         aOp_q      <= aOp_d;
         bOp_q      <= bOp_d;
         sum_q      <= sum_d;
         idx_q      <= idx_d;
         carry_q    <= carry_d;
         carryOut_q <= carryOut_d;
         overflow_q <= overflow_d;
      end
   end

   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = (state_q == DONE);
   assign c         = sum_q;
   assign carry_out = carryOut_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_chunked_sequential_adder.sv
// Directed bench for chunked_sequential_adder: a W=8 instance driven through a
// scoreboard, plus a W=N instance for the single-chunk latency case.
module tb_chunked_sequential_adder;

   localparam int N = 32;

   typedef struct packed {
      logic [N-1:0] c;
      logic         co;
      logic         ov;
   } result_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  a, b;
   logic          carryIn, sub;

   logic          inValid1, inReady1, outValid1, outReady1, co1, ov1;
   logic [N-1:0]  c1;
   logic          inValid2, inReady2, outValid2, outReady2, co2, ov2;
   logic [N-1:0]  c2;

   result_t       scoreboard[$];
   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;

   chunked_sequential_adder #(.N(N), .W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(inValid1), .in_ready(inReady1),
      .a(a), .b(b), .carry_in(carryIn), .sub(sub),
      .out_valid(outValid1), .out_ready(outReady1),
      .c(c1), .carry_out(co1), .overflow(ov1)
   );

   chunked_sequential_adder #(.N(N), .W(32)) dutWide (
      .clk(clk), .rst(rst), .in_valid(inValid2), .in_ready(inReady2),
      .a(a), .b(b), .carry_in(carryIn), .sub(sub),
      .out_valid(outValid2), .out_ready(outReady2),
      .c(c2), .carry_out(co2), .overflow(ov2)
   );

   // Reference arithmetic: subtract is a + ~b + 1 with carry_in ignored.
   function automatic result_t model(input logic [N-1:0] x, input logic [N-1:0] y,
                                     input logic ci, input logic s);
      result_t      r;
      logic [N-1:0] yp;
      logic         cin;
      logic [N:0]   full;
      yp   = s ? ~y : y;
      cin  = s ? 1'b1 : ci;
      full = {1'b0, x} + {1'b0, yp} + {{N{1'b0}}, cin};
      r.c  = full[N-1:0];
      r.co = full[N];
      r.ov = (x[N-1] == yp[N-1]) && (full[N-1] != x[N-1]);
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [N:0] observed, input logic [N:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Presents operands on the narrow instance and waits for the accepting edge.
   task automatic applyStimulus(input logic [N-1:0] x, input logic [N-1:0] y,
                                input logic ci, input logic s, input logic record);
      @(negedge clk);
      a = x; b = y; carryIn = ci; sub = s;
      checkOutput("in_ready before accept", {32'd0, inReady1}, 33'd1);
      inValid1 = 1'b1;
      @(posedge clk);
      if (record) scoreboard.push_back(model(x, y, ci, s));
      @(negedge clk);
      inValid1 = 1'b0;
   endtask

   // Called at the negedge right after the accepting edge; pops and compares one result.
   task automatic waitResult(input string tag, input int expLatency);
      result_t exp;
      int      lat;
      lat = 1;
      while (!outValid1 && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      checkOutput({tag, " out_valid"}, {32'd0, outValid1}, 33'd1);
      if (expLatency > 0) checkOutput({tag, " latency"}, 33'(lat), 33'(expLatency));
      if (scoreboard.size() == 0) begin
         checkOutput({tag, " scoreboard empty"}, 33'd0, 33'd1);
      end else begin
         exp = scoreboard.pop_front();
         checkOutput({tag, " c"},         {1'b0, c1},     {1'b0, exp.c});
         checkOutput({tag, " carry_out"}, {32'd0, co1},   {32'd0, exp.co});
         checkOutput({tag, " overflow"},  {32'd0, ov1},   {32'd0, exp.ov});
      end
      outReady1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      outReady1 = 1'b0;
      checkOutput({tag, " out_valid after handshake"}, {32'd0, outValid1}, 33'd0);
      checkOutput({tag, " in_ready after handshake"},  {32'd0, inReady1},  33'd1);
   endtask

   initial begin
      result_t      held;
      logic [N-1:0] rx, ry;
      int           lat;

      rst = 1'b1; a = '0; b = '0; carryIn = 1'b0; sub = 1'b0;
      inValid1 = 1'b0; outReady1 = 1'b0; inValid2 = 1'b0; outReady2 = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset out_valid", {32'd0, outValid1}, 33'd0);
      checkOutput("reset c",         {1'b0, c1},         33'd0);
      checkOutput("reset in_ready",  {32'd0, inReady1},  33'd0);
      rst = 1'b0;
      #1 checkOutput("in_ready after release", {32'd0, inReady1}, 33'd1);

      $display("[TB] directed arithmetic cases");
      applyStimulus(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 1'b1);
      waitResult("chunk carry", 5);
      applyStimulus(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b1);
      waitResult("full ripple", 5);
      applyStimulus(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1);
      waitResult("add overflow", 5);
      applyStimulus(32'h00000005, 32'h00000007, 1'b1, 1'b1, 1'b1);
      waitResult("sub cin ignored", 5);
      applyStimulus(32'h80000000, 32'h00000001, 1'b0, 1'b1, 1'b1);
      waitResult("sub overflow", 5);
      for (int i = 0; i < 4; i++) begin
         rx = $urandom; ry = $urandom;
         applyStimulus(rx, ry, 1'($urandom_range(0, 1)), 1'(i % 2), 1'b1);
         waitResult("random", 5);
      end

      $display("[TB] back-pressure");
      applyStimulus(32'h12345678, 32'h0F0F0F0F, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 40 && !outValid1; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
      held = model(32'h12345678, 32'h0F0F0F0F, 1'b0, 1'b1);
      a = 32'hAAAA5555; b = 32'h11112222; carryIn = 1'b1; sub = 1'b0;
      inValid1 = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput("bp out_valid",  {32'd0, outValid1}, 33'd1);
         checkOutput("bp c",          {1'b0, c1},         {1'b0, held.c});
         checkOutput("bp carry_out",  {32'd0, co1},       {32'd0, held.co});
         checkOutput("bp overflow",   {32'd0, ov1},       {32'd0, held.ov});
         checkOutput("bp in_ready",   {32'd0, inReady1},  33'd0);
      end
      void'(scoreboard.pop_front());
      outReady1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      outReady1 = 1'b0;
      checkOutput("bp in_ready after handshake", {32'd0, inReady1},  33'd1);
      checkOutput("bp out_valid dropped",        {32'd0, outValid1}, 33'd0);
      @(posedge clk);
      scoreboard.push_back(model(32'hAAAA5555, 32'h11112222, 1'b1, 1'b0));
      @(negedge clk);
      inValid1 = 1'b0;
      waitResult("bp second op", 5);

      $display("[TB] reset mid-operation");
      applyStimulus(32'h11111111, 32'h22222222, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("mid-reset out_valid", {32'd0, outValid1}, 33'd0);
      checkOutput("mid-reset c",         {1'b0, c1},         33'd0);
      checkOutput("mid-reset carry_out", {32'd0, co1},       33'd0);
      checkOutput("mid-reset overflow",  {32'd0, ov1},       33'd0);
      rst = 1'b0;
      #1 checkOutput("mid-reset in_ready", {32'd0, inReady1}, 33'd1);
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput("no stale result", {32'd0, outValid1}, 33'd0);
      end
      applyStimulus(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 1'b1);
      waitResult("after reset", 5);

      $display("[TB] single-chunk instance");
      @(negedge clk);
      a = 32'h000000FF; b = 32'h00000001; carryIn = 1'b0; sub = 1'b0;
      checkOutput("wide in_ready", {32'd0, inReady2}, 33'd1);
      inValid2 = 1'b1;
      @(posedge clk);
      held = model(32'h000000FF, 32'h00000001, 1'b0, 1'b0);
      @(negedge clk);
      inValid2 = 1'b0;
      lat = 1;
      while (!outValid2 && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      checkOutput("wide out_valid", {32'd0, outValid2}, 33'd1);
      checkOutput("wide latency",   33'(lat),           33'd2);
      checkOutput("wide c",         {1'b0, c2},         {1'b0, held.c});
      checkOutput("wide carry_out", {32'd0, co2},       {32'd0, held.co});
      checkOutput("wide overflow",  {32'd0, ov2},       {32'd0, held.ov});
      outReady2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      outReady2 = 1'b0;
      checkOutput("wide in_ready after handshake", {32'd0, inReady2}, 33'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
